// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the main control FSM, the mult/div units and the sequencer.
// The master side drives requests and unit flags; the sequencer is the slave.
interface muldiv_sequencer_if #(
  parameter int CNT_W = 7
);
  logic             req;
  logic             op;
  logic             b_is_zero;
  logic             mult_fim;
  logic             div_fim;
  logic             div_by_zero;
  logic             mult_start;
  logic             div_start;
  logic             hi_sel;
  logic             lo_sel;
  logic             hi_write;
  logic             lo_write;
  logic             busy;
  logic             done;
  logic             exc;
  logic [1:0]       exc_code;
  logic [CNT_W-1:0] last_latency;

  modport master (
    output req, op, b_is_zero, mult_fim, div_fim, div_by_zero,
    input  mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
           busy, done, exc, exc_code, last_latency
  );

  modport slave (
    input  req, op, b_is_zero, mult_fim, div_fim, div_by_zero,
    output mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
           busy, done, exc, exc_code, last_latency
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one mult/div operation: start pulse, wait for finish, HI/LO commit,
// and traps divide-by-zero and runaway operations as a single exception pulse.
module muldiv_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input logic               clock,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    EXC   = 3'd5
  } seqState;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] CODE_DIV0    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  seqState          state, nextState;
  logic             opQ;
  logic [1:0]       codeQ, nextCode;
  logic [CNT_W-1:0] cnt, lastLat;
  logic             fim, loadOp, loadLat;

  // Only the selected unit's finish flag matters; the other one is ignored.
  assign fim = opQ ? bus.div_fim : bus.mult_fim;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    nextCode  = codeQ;
    loadOp    = 1'b0;
    loadLat   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          loadOp = 1'b1;
          if (bus.op && bus.b_is_zero) begin
            nextState = EXC;
            nextCode  = CODE_DIV0;
          end else begin
            nextState = START;
          end
        end
      end
      START: nextState = WAIT;
      WAIT: begin
        // Divider's own zero report outranks a simultaneous finish.
        if (opQ && bus.div_by_zero) begin
          nextState = EXC;
          nextCode  = CODE_DIV0;
        end else if (fim) begin
          loadLat   = 1'b1;
          nextState = WRITE;
        end else if (cnt == CNT_LIMIT) begin
          nextState = EXC;
          nextCode  = CODE_TIMEOUT;
        end
      end
      WRITE:   nextState = DONE;
      DONE:    nextState = IDLE;
      EXC:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opQ     <= 1'b0;
      codeQ   <= 2'b00;
      cnt     <= '0;
      lastLat <= '0;
    end else begin
      codeQ <= nextCode;
      if (loadOp) begin
        opQ <= bus.op;
      end
      if (state == START) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (loadLat) begin
        lastLat <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy         = (state != IDLE);
    bus.hi_sel       = (state != IDLE) && opQ;
    bus.lo_sel       = (state != IDLE) && opQ;
    bus.mult_start   = (state == START) && !opQ;
    bus.div_start    = (state == START) && opQ;
    bus.hi_write     = (state == WRITE);
    bus.lo_write     = (state == WRITE);
    bus.done         = (state == DONE);
    bus.exc          = (state == EXC);
    bus.exc_code     = (state == EXC) ? codeQ : 2'b00;
    bus.last_latency = lastLat;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: cycle numbers are counted from the edge
// that samples req (cycle 1 is the START cycle).
module tb_muldiv_sequencer;

  localparam int CNT_W = 7;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  int nMultStart, nDivStart, nWrite, nDone, nExc, badCount;
  int startCycle, writeCycle, doneCycle, excCycle;
  logic [1:0] selAtWrite;
  logic [1:0] excCodeSeen;

  muldiv_sequencer_if #(.CNT_W(CNT_W)) bus ();

  muldiv_sequencer #(.TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packs every single-bit output plus exc_code for all-zero checks.
  function automatic logic [10:0] outVec();
    return {bus.mult_start, bus.div_start, bus.hi_sel, bus.lo_sel, bus.hi_write,
            bus.lo_write, bus.busy, bus.done, bus.exc, bus.exc_code};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    bus.req         = 1'b0;
    bus.op          = 1'b0;
    bus.b_is_zero   = 1'b0;
    bus.mult_fim    = 1'b0;
    bus.div_fim     = 1'b0;
    bus.div_by_zero = 1'b0;
  endtask

  // fimWait/dbzWait = k pulses the flag during the k-th WAIT cycle (0 = never).
  task automatic applyStimulus(input logic opIn, input logic bzIn, input int fimWait,
                               input int dbzWait, input bit interfere,
                               input int reqAgain, input int maxCycles);
    nMultStart = 0; nDivStart = 0; nWrite = 0; nDone = 0; nExc = 0; badCount = 0;
    startCycle = -1; writeCycle = -1; doneCycle = -1; excCycle = -1;
    selAtWrite = 2'b00; excCodeSeen = 2'b00;
    @(negedge clock);
    clearInputs();
    bus.req       = 1'b1;
    bus.op        = opIn;
    bus.b_is_zero = bzIn;
    for (int n = 1; n <= maxCycles; n++) begin
      @(negedge clock);
      if (bus.mult_start) begin nMultStart++; startCycle = n; end
      if (bus.div_start)  begin nDivStart++;  startCycle = n; end
      if (bus.hi_write || bus.lo_write) begin
        nWrite++;
        writeCycle = n;
        selAtWrite = {bus.hi_sel, bus.lo_sel};
        if (bus.hi_write != bus.lo_write) badCount++;
      end
      if (bus.done) begin nDone++; doneCycle = n; end
      if (bus.exc) begin
        nExc++;
        excCycle    = n;
        excCodeSeen = bus.exc_code;
      end else if (bus.exc_code != 2'b00) begin
        badCount++;
      end
      if (!bus.busy && (bus.hi_sel || bus.lo_sel)) badCount++;
      bus.req       = (n == reqAgain);
      bus.b_is_zero = 1'b0;
      if (opIn) begin
        bus.div_fim     = (fimWait > 0) && (n == fimWait + 1);
        bus.div_by_zero = (dbzWait > 0) && (n == dbzWait + 1);
        bus.mult_fim    = interfere ? n[0] : 1'b0;
      end else begin
        bus.mult_fim    = (fimWait > 0) && (n == fimWait + 1);
        bus.div_fim     = interfere ? n[0] : 1'b0;
        bus.div_by_zero = interfere ? ~n[0] : 1'b0;
      end
    end
    clearInputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearInputs();
    reset = 1'b0;

    // Reset held low from time zero, then released with req idle.
    #7;
    checkOutput("reset_outputs", 32'(outVec()), 32'd0);
    checkOutput("reset_latency", 32'(bus.last_latency), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("post_reset_outputs", 32'(outVec()), 32'd0);

    // Multiply, finish in 32nd WAIT cycle, divider flags toggling.
    applyStimulus(1'b0, 1'b0, 32, 0, 1'b1, 0, 40);
    checkOutput("mul_start_count", nMultStart, 1);
    checkOutput("mul_div_start_count", nDivStart, 0);
    checkOutput("mul_start_cycle", startCycle, 1);
    checkOutput("mul_write_cycle", writeCycle, 34);
    checkOutput("mul_write_sel", 32'(selAtWrite), 32'd0);
    checkOutput("mul_done_cycle", doneCycle, 35);
    checkOutput("mul_done_count", nDone, 1);
    checkOutput("mul_exc_count", nExc, 0);
    checkOutput("mul_latency", 32'(bus.last_latency), 32'd32);
    checkOutput("mul_glitches", badCount, 0);

    // Zero divisor fast path.
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 0, 5);
    checkOutput("z0_exc_cycle", excCycle, 1);
    checkOutput("z0_exc_code", 32'(excCodeSeen), 32'd1);
    checkOutput("z0_div_start", nDivStart, 0);
    checkOutput("z0_write_count", nWrite, 0);
    checkOutput("z0_done_count", nDone, 0);
    checkOutput("z0_latency", 32'(bus.last_latency), 32'd32);

    // Divide, finish after 10 WAIT cycles, mult_fim toggling.
    applyStimulus(1'b1, 1'b0, 10, 0, 1'b1, 0, 16);
    checkOutput("div_start_count", nDivStart, 1);
    checkOutput("div_mult_start", nMultStart, 0);
    checkOutput("div_write_cycle", writeCycle, 12);
    checkOutput("div_write_sel", 32'(selAtWrite), 32'd3);
    checkOutput("div_done_cycle", doneCycle, 13);
    checkOutput("div_exc_count", nExc, 0);
    checkOutput("div_latency", 32'(bus.last_latency), 32'd10);
    checkOutput("div_glitches", badCount, 0);

    // div_fim and div_by_zero together: exception wins.
    applyStimulus(1'b1, 1'b0, 5, 5, 1'b0, 0, 10);
    checkOutput("dbz_exc_cycle", excCycle, 7);
    checkOutput("dbz_exc_code", 32'(excCodeSeen), 32'd1);
    checkOutput("dbz_write_count", nWrite, 0);
    checkOutput("dbz_done_count", nDone, 0);
    checkOutput("dbz_latency", 32'(bus.last_latency), 32'd10);

    // Divider never finishes: timeout after 64 WAIT cycles.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 70);
    checkOutput("to_exc_cycle", excCycle, 66);
    checkOutput("to_exc_code", 32'(excCodeSeen), 32'd2);
    checkOutput("to_exc_count", nExc, 1);
    checkOutput("to_write_count", nWrite, 0);
    checkOutput("to_latency", 32'(bus.last_latency), 32'd10);
    checkOutput("to_glitches", badCount, 0);

    // Second req during WAIT is ignored; then reset mid-WAIT.
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 5, 10);
    checkOutput("busy_start_count", nMultStart, 1);
    checkOutput("busy_done_count", nDone, 0);
    checkOutput("busy_still_busy", 32'(bus.busy), 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_outputs", 32'(outVec()), 32'd0);
    repeat (2) @(negedge clock);
    checkOutput("midreset_held", 32'(outVec()), 32'd0);
    checkOutput("midreset_latency", 32'(bus.last_latency), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_release", 32'(outVec()), 32'd0);

    // Normal operation after reset release.
    applyStimulus(1'b0, 1'b0, 3, 0, 1'b0, 0, 8);
    checkOutput("after_start_count", nMultStart, 1);
    checkOutput("after_done_cycle", doneCycle, 6);
    checkOutput("after_latency", 32'(bus.last_latency), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Control-side sequencer for the shared multiplier/divider pair in the multicycle CPU. The main control FSM issues one request, and this block does the rest: it pulses the selected unit's start, waits for its finish flag, commits HI/LO through the HI/LO source muxes, and reports either completion or an exception. It also traps divide-by-zero and runaway operations, so the main FSM needs only one wait state for all mult/div instructions.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before a timeout exception; legal range 2..127.
- CNT_W, 7: width of the cycle counter and of `last_latency`; must satisfy 2^CNT_W > TIMEOUT.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- req  in  1  request from control FSM; sampled only in IDLE.
- op  in  1  0 = mult, 1 = div; sampled with `req`.
- b_is_zero  in  1  divisor operand (B register) equals 0; sampled with `req`.
- mult_fim  in  1  multiplier finished.
- div_fim  in  1  divider finished.
- div_by_zero  in  1  divider-reported divide-by-zero.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- div_start  out  1  one-cycle start pulse to the divider.
- hi_sel  out  1  HI source mux select (0 mult, 1 div).
- lo_sel  out  1  LO source mux select (0 mult, 1 div).
- hi_write  out  1  HI register load enable.
- lo_write  out  1  LO register load enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- exc  out  1  one-cycle exception pulse.
- exc_code  out  2  01 = divide-by-zero, 10 = timeout; valid only while `exc` is high, 00 otherwise.
- last_latency  out  CNT_W  WAIT-cycle count of the last successful operation.

## Operation
- States: IDLE, START, WAIT, WRITE, DONE, EXC. The state and the registered `op_q` drive all outputs.
- **IDLE**
  - If `req`=1, latch `op` into `op_q`.
  - If `op`=1 and `b_is_zero`=1, go to EXC with code 01.
  - Otherwise go to START.
- **START**
  - Assert `mult_start` if `op_q`=0, or `div_start` if `op_q`=1.
  - Clear the counter. Go to WAIT.
- **WAIT**
  - The counter increments each cycle. The finish flag of the selected unit is `fim`. The other unit's `fim` is ignored.
  - Priority 1: if `op_q`=1 and `div_by_zero`=1, go to EXC with code 01.
  - Priority 2: if `fim`=1, load `last_latency` with counter+1 and go to WRITE.
  - Priority 3: if counter = TIMEOUT-1, go to EXC with code 10.
- **WRITE:** `hi_write`=`lo_write`=1 for one cycle. Go to DONE.
- **DONE:** `done`=1 for one cycle. Go to IDLE.
- **EXC:** `exc`=1 and `exc_code` valid for one cycle; HI/LO are never written. Go to IDLE.
- `hi_sel`=`lo_sel`=`op_q` while `busy`=1, and 0 in IDLE.
- `req` is ignored while `busy`=1; requests are not queued.
- `last_latency` is unchanged on exceptions.

## Timing
- **Reset:** state IDLE, `op_q`=0, counter=0, `last_latency`=0. All outputs are 0, including `exc_code`=00.
- **Reset mid-operation:** immediate return to IDLE. No write, done, exc or start pulse follows. The external unit's state is not this block's concern.
- **Normal latency:**
  - Edge E0 samples `req`; `start` is high during the cycle after E0.
  - `fim` first sampled at edge Ek: `hi_write`/`lo_write` are high in the next cycle, and `done` in the cycle after that.
  - Total from `req` to `done` = `last_latency` + 3 cycles.
- **Zero-divisor fast path:** `exc` is high in the cycle immediately after the `req` edge; `div_start` is never asserted.
- **Timeout:** `exc` is high in the cycle after the TIMEOUT-th WAIT cycle.
- **Back-to-back:** a new `req` is accepted on the first IDLE cycle after DONE or EXC, so the minimum request spacing is `last_latency` + 4 cycles.
- Start pulses are exactly one cycle wide and are never reissued within one operation.

## Test plan
- **Reset:** assert `reset`=0 mid-clock -> all outputs are 0 asynchronously and stay 0 while `reset` is held low; after release with `req`=0 the outputs remain 0.
- **Multiplication:** `req`=1, `op`=0; `mult_fim` pulsed in the 32nd WAIT cycle -> one `mult_start` pulse, `hi_write`=`lo_write`=1 with `hi_sel`=`lo_sel`=0, `done` 35 cycles after the `req` edge, `last_latency`=32.
- **Zero divisor:** `req`=1, `op`=1, `b_is_zero`=1 -> `exc`=1 with `exc_code`=01 in the next cycle, `div_start` stays 0, no HI/LO write.
- **Division with interference:** `op`=1, `div_fim` after 10 WAIT cycles, `mult_fim` toggling throughout -> `mult_fim` ignored, `hi_sel`=`lo_sel`=1 on the write, `last_latency`=10. A second case where `div_fim` and `div_by_zero` rise in the same cycle -> `exc_code`=01 and no write.
- **Timeout:** TIMEOUT=64, `op`=1, `div_fim` held at 0 -> `exc`=1 with `exc_code`=10 exactly 64 WAIT cycles after START; `last_latency` keeps its previous value.
- **Busy and reset mid-WAIT:** a `req` pulsed during WAIT is ignored (no second start). Then `reset`=0 during WAIT -> immediate return to IDLE and no `done`; a new `req` after reset release runs normally.
